aes_byte_scanner: RTL and testbench

- Downstream display stage for the AES encrypt/decrypt cores.
- Captures one finished 128-bit block (ciphertext or recovered plaintext) on a valid strobe. Steps through its 16 bytes, one at a time, and converts each byte to 3-digit BCD with a sequential 8-iteration double-dabble.
- Presents each byte and its BCD value for a programmable dwell time.
- Feeds the existing 7-segment display decoders, replacing the single fixed byte [7:0] view.

---
 rtl/aes_byte_scanner.sv | 139 +++++++++++++
 tb/tb_aes_byte_scanner.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_scanner.sv
// aes_byte_scanner: captures one 128-bit AES block and walks its 16 bytes,
// converting each to 3-digit BCD with an 8-step double-dabble. Each byte and
// its BCD value are then held for a programmable dwell time for the 7-segment
// display decoders.
module aes_byte_scanner #(
    parameter int unsigned STEP_CYCLES = 4,  // dwell cycles per byte, 1..65535
    parameter int unsigned LOOP        = 0   // 0: single scan, 1: wrap forever
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] block_in,
    input  logic         block_valid,
    input  logic         pause,
    output logic         busy,
    output logic [3:0]   byte_idx,
    output logic [7:0]   byte_out,
    output logic [11:0]  bcd_out,
    output logic         bcd_valid,
    output logic         done,
    output logic         overrun
);

    typedef enum logic [1:0] {StIdle, StConvert, StHold} StateT;

    localparam logic        Wrap     = (LOOP != 0);
    localparam logic [15:0] StepLoad = 16'(STEP_CYCLES);

    StateT        state;
    logic [127:0] blockReg;
    logic [11:0]  bcdWork;   // partial BCD result during conversion
    logic [7:0]   srcShift;  // source byte, MSB shifted out first
    logic [2:0]   iterCnt;
    logic [15:0]  dwellCnt;

    logic [2:0]   hundAdj;
    logic [3:0]   tensAdj;
    logic [3:0]   onesAdj;
    logic [11:0]  bcdNext;
    logic [3:0]   nextIdx;
    logic [7:0]   nextByte;
    logic         accept;

    assign busy = (state != StIdle);

    // One double-dabble step: add 3 to digits >= 5, then shift in the next source bit.
    always_comb begin
        // Hundreds never exceeds 2 before the final shift, so its top bit is always dropped.
        hundAdj = 3'(bcdWork[11:8] + ((bcdWork[11:8] >= 4'd5) ? 4'd3 : 4'd0));
        tensAdj = bcdWork[7:4] + ((bcdWork[7:4] >= 4'd5) ? 4'd3 : 4'd0);
        onesAdj = bcdWork[3:0] + ((bcdWork[3:0] >= 4'd5) ? 4'd3 : 4'd0);
        bcdNext = {hundAdj, tensAdj, onesAdj, srcShift[7]};
    end

    // Next byte selection (15 wraps to 0) and new-block acceptance.
    always_comb begin
        nextIdx  = byte_idx + 4'd1;
        // Byte i lives at bit offset 8*(15-i), i.e. {~i, 3'b000}.
        nextByte = 8'(blockReg >> {~nextIdx, 3'b000});
        // In wrap mode a new block preempts the scan from any state.
        accept   = block_valid && ((state == StIdle) || Wrap);
    end

    // Scan FSM: capture, per-byte conversion, dwell, advance; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            blockReg  <= '0;
            bcdWork   <= '0;
            srcShift  <= '0;
            iterCnt   <= '0;
            dwellCnt  <= '0;
            byte_idx  <= '0;
            byte_out  <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                blockReg  <= block_in;
                byte_idx  <= '0;
                byte_out  <= block_in[127:120];
                srcShift  <= block_in[127:120];
                bcdWork   <= '0;
                iterCnt   <= '0;
                dwellCnt  <= '0;
                bcd_valid <= 1'b0;
                state     <= StConvert;
                if (state == StIdle) begin
                    overrun <= 1'b0;
                end
            end else begin
                // Only reachable with a block in flight when not wrapping: drop it, flag it.
                if (block_valid && (state != StIdle)) begin
                    overrun <= 1'b1;
                end
                case (state)
                    StConvert: begin
                        bcdWork  <= bcdNext;
                        srcShift <= {srcShift[6:0], 1'b0};
                        iterCnt  <= iterCnt + 3'd1;
                        if (iterCnt == 3'd7) begin
                            bcd_out   <= bcdNext;
                            bcd_valid <= 1'b1;
                            dwellCnt  <= StepLoad;
                            state     <= StHold;
                        end
                    end
                    StHold: begin
                        if (!pause) begin
                            if (dwellCnt == 16'd1) begin
                                dwellCnt  <= '0;
                                bcd_valid <= 1'b0;
                                if ((byte_idx == 4'd15) && !Wrap) begin
                                    done  <= 1'b1;
                                    state <= StIdle;
                                end else begin
                                    byte_idx <= nextIdx;
                                    byte_out <= nextByte;
                                    srcShift <= nextByte;
                                    bcdWork  <= '0;
                                    iterCnt  <= '0;
                                    state    <= StConvert;
                                end
                            end else begin
                                dwellCnt <= dwellCnt - 16'd1;
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_byte_scanner.sv
// Bench for aes_byte_scanner: directed blocks, expected byte/BCD/dwell entries
// queued at stimulus time and checked by a monitor on each bcd_valid window.
module tb_aes_byte_scanner;

    localparam int unsigned S0 = 4;   // single-scan instance dwell
    localparam int unsigned S1 = 2;   // wrapping instance dwell
    localparam logic [127:0] BlkX   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BlkAlt = 128'h00ff00ff00ff00ff00ff00ff00ff00ff;

    typedef struct {
        logic [3:0]  idx;
        logic [7:0]  byt;
        logic [11:0] bcd;
        int          hold;
    } exp_t;

    logic clk;
    logic reset0, reset1;
    logic [127:0] bi0, bi1;
    logic bv0, bv1, pause0, pause1;
    logic busy0, busy1, valid0, valid1, done0, done1, ovr0, ovr1;
    logic [3:0] idx0, idx1;
    logic [7:0] byte0, byte1;
    logic [11:0] bcd0, bcd1;

    int cyc = 0;
    int nChecks = 0;
    int nErrors = 0;
    int done1Cnt = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   dq0[$];
    logic prevV [2];
    int   holdCnt [2];
    exp_t cur [2];

    aes_byte_scanner #(.STEP_CYCLES(S0), .LOOP(0)) dut0 (
        .clk(clk), .reset(reset0), .block_in(bi0), .block_valid(bv0), .pause(pause0),
        .busy(busy0), .byte_idx(idx0), .byte_out(byte0), .bcd_out(bcd0),
        .bcd_valid(valid0), .done(done0), .overrun(ovr0)
    );

    aes_byte_scanner #(.STEP_CYCLES(S1), .LOOP(1)) dut1 (
        .clk(clk), .reset(reset1), .block_in(bi1), .block_valid(bv1), .pause(pause1),
        .busy(busy1), .byte_idx(idx1), .byte_out(byte1), .bcd_out(bcd1),
        .bcd_valid(valid1), .done(done1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decimal reference: digits by division, independent of the shift-and-add method.
    function automatic logic [11:0] decBcd(input logic [7:0] b);
        int v;
        v = int'(b);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] byteOf(input logic [127:0] d, input int n);
        return d[127 - 8 * n -: 8];
    endfunction

    task automatic pushExp(input int d, input logic [127:0] blk, input int n, input int hold);
        exp_t e;
        e.idx  = 4'(n);
        e.byt  = byteOf(blk, n);
        e.bcd  = decBcd(e.byt);
        e.hold = hold;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pushBlock0(input logic [127:0] blk, input int k, input int pauseByte,
                              input int pauseLen);
        for (int n = 0; n < 16; n++) begin
            pushExp(0, blk, n, int'(S0) + ((n == pauseByte) ? pauseLen : 0));
        end
        dq0.push_back(k + 16 * (8 + int'(S0)) + pauseLen);
    endtask

    // Monitor step for one instance: pop on a rising bcd_valid, check dwell on its fall.
    task automatic monStep(input int d, input string tag, input logic v, input logic [3:0] idx,
                           input logic [7:0] byt, input logic [11:0] bcd);
        exp_t e;
        int   qs;
        if (v === 1'b1) begin
            chk({tag, ".digitsOk"},
                {31'b0, (bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9)}, 1);
            if (prevV[d] !== 1'b1) begin
                qs = (d == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("FAIL %s.unexpectedValid: got idx %0h, required no output", tag, idx);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk({tag, ".idx"}, {28'b0, idx}, {28'b0, e.idx});
                    chk({tag, ".byte"}, {24'b0, byt}, {24'b0, e.byt});
                    chk({tag, ".bcd"}, {20'b0, bcd}, {20'b0, e.bcd});
                    cur[d] = e;
                end
                holdCnt[d] = 1;
            end else begin
                holdCnt[d]++;
            end
        end else if (prevV[d] === 1'b1) begin
            chk({tag, ".dwell"}, holdCnt[d], cur[d].hold);
        end
        prevV[d] = (v === 1'b1);
    endtask

    always @(negedge clk) begin
        monStep(0, "mon0", valid0, idx0, byte0, bcd0);
        monStep(1, "mon1", valid1, idx1, byte1, bcd1);
        if (done0 === 1'b1) begin
            if (dq0.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL done0.unexpected: got pulse, required none (cycle %0d)", cyc);
            end else begin
                chk("done0.cycle", cyc, dq0.pop_front());
                chk("done0.busy", {31'b0, busy0}, 0);
            end
        end
        if (done1 === 1'b1) done1Cnt++;
    end

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic issue0(input logic [127:0] d, output int k);
        bi0 = d;
        bv0 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        bv0 = 1'b0;
    endtask

    task automatic issue1(input logic [127:0] d, output int k);
        bi1 = d;
        bv1 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        bv1 = 1'b0;
    endtask

    task automatic waitDrain0(input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || dq0.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s.drain: got %0d entries left, required 0", tag, q0.size() + dq0.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k, kx, k2;
        prevV[0] = 1'b0;
        prevV[1] = 1'b0;
        holdCnt[0] = 0;
        holdCnt[1] = 0;
        reset0 = 1'b1; reset1 = 1'b1;
        bv0 = 1'b0; bv1 = 1'b0; pause0 = 1'b0; pause1 = 1'b0;
        bi0 = '0; bi1 = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", {31'b0, busy0}, 0);
        chk("rst.idx", {28'b0, idx0}, 0);
        chk("rst.byte", {24'b0, byte0}, 0);
        chk("rst.bcd", {20'b0, bcd0}, 0);
        chk("rst.valid", {31'b0, valid0}, 0);
        chk("rst.done", {31'b0, done0}, 0);
        chk("rst.overrun", {31'b0, ovr0}, 0);
        chk("rst1.busy", {31'b0, busy1}, 0);
        reset0 = 1'b0; reset1 = 1'b0;
        @(negedge clk);

        // A: reference block, single scan
        issue0(BlkX, k);
        pushBlock0(BlkX, k, -1, 0);
        chk("A.busy", {31'b0, busy0}, 1);
        waitUntil(k + 7);
        chk("A.validEarly", {31'b0, valid0}, 0);
        waitUntil(k + 8);
        chk("A.firstValid", {31'b0, valid0}, 1);
        chk("A.firstBcd", {20'b0, bcd0}, 32'h105);
        waitUntil(k + 14);
        chk("A.bcdHeldInConvert", {20'b0, bcd0}, 32'h105);
        chk("A.validInConvert", {31'b0, valid0}, 0);
        waitUntil(k + 20);
        chk("A.byte1Idx", {28'b0, idx0}, 1);
        chk("A.byte1Bcd", {20'b0, bcd0}, 32'h196);
        waitUntil(k + 44);
        chk("A.byte3Bcd", {20'b0, bcd0}, 32'h216);
        waitUntil(k + 188);
        chk("A.byte15Idx", {28'b0, idx0}, 15);
        chk("A.byte15Bcd", {20'b0, bcd0}, 32'h090);
        waitUntil(k + 191);
        chk("A.doneEarly", {31'b0, done0}, 0);
        waitUntil(k + 192);
        chk("A.done", {31'b0, done0}, 1);
        waitUntil(k + 193);
        chk("A.doneOnce", {31'b0, done0}, 0);
        chk("A.idleBusy", {31'b0, busy0}, 0);
        waitDrain0("A");

        // B: alternating 00/ff block
        issue0(BlkAlt, k);
        pushBlock0(BlkAlt, k, -1, 0);
        waitUntil(k + 20);
        chk("B.oddBcd", {20'b0, bcd0}, 32'h255);
        waitDrain0("B");

        // C: dropped block during scan plus a 10-cycle pause on byte 2
        issue0(BlkX, k);
        pushBlock0(BlkX, k, 2, 10);
        waitUntil(k + 29);
        chk("C.overrunBefore", {31'b0, ovr0}, 0);
        issue0(BlkAlt, kx);
        waitUntil(k + 31);
        chk("C.overrunSet", {31'b0, ovr0}, 1);
        waitUntil(k + 32);
        pause0 = 1'b1;
        waitUntil(k + 37);
        chk("C.pausedIdx", {28'b0, idx0}, 2);
        chk("C.pausedBcd", {20'b0, bcd0}, 32'h224);
        chk("C.pausedValid", {31'b0, valid0}, 1);
        waitUntil(k + 42);
        pause0 = 1'b0;
        waitUntil(k + 46);
        chk("C.resumedIdx", {28'b0, idx0}, 3);
        waitUntil(k + 201);
        chk("C.doneEarly", {31'b0, done0}, 0);
        waitDrain0("C");
        chk("C.overrunSticky", {31'b0, ovr0}, 1);

        // D: accept clears overrun; block on the final dwell edge is dropped
        issue0(BlkAlt, k);
        pushBlock0(BlkAlt, k, -1, 0);
        chk("D.overrunCleared", {31'b0, ovr0}, 0);
        waitUntil(k + 191);
        issue0(BlkX, kx);
        chk("D.overrunAtEnd", {31'b0, ovr0}, 1);
        chk("D.busyAtEnd", {31'b0, busy0}, 0);
        waitUntil(k + 195);
        chk("D.notLatchedBusy", {31'b0, busy0}, 0);
        chk("D.notLatchedIdx", {28'b0, idx0}, 15);
        chk("D.notLatchedByte", {24'b0, byte0}, 32'hff);
        waitDrain0("D");

        // E: reset and block_valid on the same edge
        bi0 = BlkX;
        bv0 = 1'b1;
        reset0 = 1'b1;
        @(negedge clk);
        bv0 = 1'b0;
        reset0 = 1'b0;
        chk("E.overrun", {31'b0, ovr0}, 0);
        chk("E.idx", {28'b0, idx0}, 0);
        chk("E.byte", {24'b0, byte0}, 0);
        chk("E.bcd", {20'b0, bcd0}, 0);
        repeat (3) @(negedge clk);
        chk("E.busy", {31'b0, busy0}, 0);

        // F: wrapping instance
        issue1(BlkAlt, k);
        for (int n = 0; n < 16; n++) pushExp(1, BlkAlt, n, int'(S1));
        pushExp(1, BlkAlt, 0, int'(S1));
        pushExp(1, BlkAlt, 1, 1);
        waitUntil(k + 158);
        chk("F.lastIdx", {28'b0, idx1}, 15);
        waitUntil(k + 160);
        chk("F.wrapIdx", {28'b0, idx1}, 0);
        chk("F.wrapBusy", {31'b0, busy1}, 1);
        waitUntil(k + 178);
        chk("F.lap2Idx", {28'b0, idx1}, 1);
        issue1(BlkX, k2);
        chk("F.restartIdx", {28'b0, idx1}, 0);
        chk("F.restartByte", {24'b0, byte1}, 32'h69);
        chk("F.restartValid", {31'b0, valid1}, 0);
        chk("F.overrun", {31'b0, ovr1}, 0);
        for (int n = 0; n < 3; n++) pushExp(1, BlkX, n, int'(S1));
        waitUntil(k2 + 8);
        chk("F.newFirstBcd", {20'b0, bcd1}, 32'h105);
        waitUntil(k2 + 33);
        chk("F.preResetByte", {24'b0, byte1}, 32'hd8);
        chk("F.preResetBcd", {20'b0, bcd1}, 32'h224);
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        chk("F.rstIdx", {28'b0, idx1}, 0);
        chk("F.rstByte", {24'b0, byte1}, 0);
        chk("F.rstBcd", {20'b0, bcd1}, 0);
        chk("F.rstValid", {31'b0, valid1}, 0);
        chk("F.rstBusy", {31'b0, busy1}, 0);
        chk("F.rstOverrun", {31'b0, ovr1}, 0);
        chk("F.queueEmpty", q1.size(), 0);
        repeat (3) @(negedge clk);
        chk("F.noDone", done1Cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
